// File: rtl/rect_list_packer.sv
// rect_list_packer: packs a per-frame rectangle beat list into flat buses and commits it on frame-sync rise
module rect_list_packer #(
   parameter int RECT_NUMMAX = 8,
   parameter int P_W         = 8,
   parameter int POSI_W      = 64,
   parameter int CNT_W       = 4
) (
   input  logic                            sys_clk,
   input  logic                            sys_rst,
   input  logic                            i_vs,
   input  logic                            i_rect_valid,
   output logic                            o_rect_ready,
   input  logic [4*P_W-1:0]                i_rect_head,
   input  logic [4*P_W-1:0]                i_rect_hair,
   input  logic [POSI_W-1:0]               i_rect_posi,
   input  logic                            i_list_done,
   output logic [RECT_NUMMAX*4*P_W-1:0]    o_head_wire,
   output logic [RECT_NUMMAX*4*P_W-1:0]    o_hair_wire,
   output logic [RECT_NUMMAX*POSI_W-1:0]   o_posi_wire,
   output logic [CNT_W-1:0]                o_rect_count,
   output logic                            o_start,
   output logic                            o_drop
);
   localparam int BW = 4 * P_W;
   typedef enum logic {S_COLLECT = 1'b0, S_PENDING = 1'b1} state_t;
   state_t                          r_state, w_state_nxt;
   logic                            r_vs_d;
   logic [CNT_W-1:0]                r_wr_cnt;
   logic [RECT_NUMMAX*BW-1:0]       r_sh_head, r_sh_hair, r_head_wire, r_hair_wire;
   logic [RECT_NUMMAX*POSI_W-1:0]   r_sh_posi, r_posi_wire;
   logic [CNT_W-1:0]                r_rect_count;
   logic                            r_start, r_drop;
   logic                            w_vs_rise, w_full, w_accept, w_store, w_commit;
   assign w_vs_rise    = i_vs & ~r_vs_d;
   assign w_full       = (r_wr_cnt == CNT_W'(RECT_NUMMAX));
   assign o_head_wire  = r_head_wire;
   assign o_hair_wire  = r_hair_wire;
   assign o_posi_wire  = r_posi_wire;
   assign o_rect_count = r_rect_count;
   assign o_start      = r_start;
   assign o_drop       = r_drop;
   // state register
   always_ff @(posedge sys_clk) begin
      if (sys_rst) r_state <= S_COLLECT;
      else         r_state <= w_state_nxt;
   end
   // next state: list done parks the list, frame-sync rise releases it
   always_comb begin
      w_state_nxt = (r_state == S_COLLECT) ? (i_list_done ? S_PENDING : S_COLLECT)
                                           : (w_vs_rise ? S_COLLECT : S_PENDING);
   end
   // FSM outputs: ready only while collecting, commit only from a parked list
   always_comb begin
      o_rect_ready = (r_state == S_COLLECT);
      w_accept     = i_rect_valid & o_rect_ready;
      w_store      = w_accept & ~w_full;
      w_commit     = (r_state == S_PENDING) & w_vs_rise;
   end
   // shadow fill, overflow drop, and commit of shadow to the output buses
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         r_vs_d       <= 1'b0;
         r_wr_cnt     <= '0;
         r_sh_head    <= '0;
         r_sh_hair    <= '0;
         r_sh_posi    <= '0;
         r_head_wire  <= '0;
         r_hair_wire  <= '0;
         r_posi_wire  <= '0;
         r_rect_count <= '0;
         r_start      <= 1'b0;
         r_drop       <= 1'b0;
      end else begin
         r_vs_d  <= i_vs;
         r_start <= w_commit;
         r_drop  <= w_accept & w_full;
         if (w_commit) begin
            r_head_wire  <= r_sh_head;
            r_hair_wire  <= r_sh_hair;
            r_posi_wire  <= r_sh_posi;
            r_rect_count <= r_wr_cnt;
            r_sh_head    <= '0;
            r_sh_hair    <= '0;
            r_sh_posi    <= '0;
            r_wr_cnt     <= '0;
         end else if (w_store) begin
            for (int k = 0; k < RECT_NUMMAX; k++) begin
               if (r_wr_cnt == CNT_W'(k)) begin
                  r_sh_head[k*BW +: BW]         <= i_rect_head;
                  r_sh_hair[k*BW +: BW]         <= i_rect_hair;
                  r_sh_posi[k*POSI_W +: POSI_W] <= i_rect_posi;
               end
            end
            r_wr_cnt <= r_wr_cnt + CNT_W'(1);
         end
      end
   end
endmodule

// File: doc/rect_list_packer.md
Name: rect_list_packer

Overview:
- Upstream neighbour of the rectangle/ASCII overlay stage.
- Receives the per-frame list of detected rectangles from the detection stage as a valid/ready beat stream and packs the list into the flat head/hair/possibility buses the overlay consumes.
- Commits a completed list only on a frame-sync rising edge, so the overlay never sees a list change mid-frame, and pulses o_start on each commit.

Parameters:
RECT_NUMMAX, 8, maximum rectangles held per frame (slots)
P_W, 8, coordinate width; one box = 4*P_W bits (x1,y1,x2,y2, x1 in LSBs), 32 at default
POSI_W, 64, possibility field width per rectangle
CNT_W, 4, width of slot counter; must satisfy 2^CNT_W > RECT_NUMMAX

Ports:
sys_clk  in  1  system clock; all logic on rising edge
sys_rst  in  1  synchronous reset, active-high
i_vs  in  1  video frame sync, same clock domain
i_rect_valid  in  1  rectangle beat valid
o_rect_ready  out  1  beat accepted when valid&ready
i_rect_head  in  4*P_W  head box of beat
i_rect_hair  in  4*P_W  hair box of beat
i_rect_posi  in  POSI_W  possibility field of beat
i_list_done  in  1  one-cycle pulse: current list complete; a beat accepted in the same cycle belongs to the list
o_head_wire  out  RECT_NUMMAX*4*P_W  committed head boxes, slot k at bits [k*4*P_W +: 4*P_W]
o_hair_wire  out  RECT_NUMMAX*4*P_W  committed hair boxes, same packing
o_posi_wire  out  RECT_NUMMAX*POSI_W  committed possibility fields
o_rect_count  out  CNT_W  number of valid slots in committed list
o_start  out  1  one-cycle pulse coincident with first cycle of new committed outputs
o_drop  out  1  one-cycle pulse when an accepted beat is discarded (list full)

Behaviour:
- Reset (sys_rst=1 at a clock edge):
  - All outputs 0, including the o_*_wire buses and o_rect_count.
  - Shadow buffer zeroed, wr_cnt=0, vs_d=0, state=COLLECT.
  - Reset overrides any simultaneous beat, i_list_done, or vs edge; a partially collected list is discarded.
- Frame-edge detect: vs_d registers i_vs; vs_rise = i_vs & ~vs_d.
- State COLLECT:
  - o_rect_ready=1.
  - Accepted beat with wr_cnt<RECT_NUMMAX: write head/hair/posi into shadow slot wr_cnt, then wr_cnt+1.
  - Accepted beat with wr_cnt==RECT_NUMMAX: discard the beat, o_drop=1 next cycle, wr_cnt holds (no wrap).
  - i_list_done=1 -> PENDING; a beat accepted that cycle is stored first.
  - vs_rise in COLLECT is ignored: no commit, outputs hold the previous list.
- State PENDING:
  - o_rect_ready=0; beats and further i_list_done pulses are ignored.
  - On vs_rise: copy shadow to output buses, o_rect_count=wr_cnt, o_start=1 for exactly the next cycle (new outputs valid that same cycle).
  - In the same cycle: clear all shadow slots to 0 and set wr_cnt=0 -> COLLECT.
- Slots k>=o_rect_count are always 0 in the outputs; all-zero boxes are drawn as nothing downstream.
- i_list_done and vs_rise in the same cycle while in COLLECT: enter PENDING; commit waits for the next vs_rise.
- Empty list (i_list_done with no beats) commits count 0 and all-zero buses, and still pulses o_start.
- Output buses change only on commit or reset; they are registered with no combinational path from the inputs.
- o_rect_ready is a registered function of state only.
- Latency: vs_rise at edge N -> o_start and new buses visible in cycle N+1.

Test Plan:
- Reset, then 3 beats (head=0x10203040+k, hair=0x50607080+k, posi=k), i_list_done, then vs rise -> o_start one cycle; o_rect_count=3; slots 0..2 match the beats; slots 3..7 are 0.
- Beats during PENDING with valid held high -> o_rect_ready=0, nothing stored; after commit ready=1 and the held beat goes to slot 0.
- 10 beats in one list -> slots 0..7 stored; o_drop pulses twice (beats 9, 10); committed count=8; beats 9 and 10 absent from the outputs.
- vs rise before i_list_done -> no o_start, outputs unchanged; the next vs rise after i_list_done commits.
- i_list_done alone (empty list) while 5 rects are displayed -> on vs rise o_start=1, count=0, all buses 0.
- sys_rst asserted mid-list (2 beats stored) -> all outputs 0; the next list of 1 beat commits count=1 with no residue in slot 1.
